// File: rtl/ifetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ifetch_pkg
// Purpose  : Shared types and constants for the RV32I instruction fetch stage.
// Revision : 1.0 - initial release
// ============================================================================
package ifetch_pkg;

    localparam int DATA_W = 32;
    localparam logic [1:0] INSTR_ALIGN_MASK = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [DATA_W-1:0] addr;
        logic [DATA_W-1:0] instr;
    } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/ifetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : ifetch_queue
// Purpose  : Registered synchronous FIFO holding fetched {addr, instr} entries.
// Revision : 1.0 - initial release
// ============================================================================
module ifetch_queue #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic                     i_clear,
    input  logic [WIDTH-1:0]         i_wdata,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] c_full_count = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == c_full_count);
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_rdata   = r_mem[r_rd_ptr];
    // A push into a full queue is legal only when the head leaves in the same cycle
    assign w_do_push = i_push && (!o_full || i_pop);
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (w_do_push && !i_clear && !rst) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/ifetch_r32i.sv
`default_nettype none
// ============================================================================
// Module   : ifetch_r32i
// Purpose  : RV32I fetch stage: req/gnt memory reads, tagged instruction queue.
// Revision : 1.0 - initial release
// ============================================================================
module ifetch_r32i
    import ifetch_pkg::*;
#(
    parameter int dataW = DATA_W,
    parameter int DEPTH = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [dataW-1:0] ProgAddr,
    output logic             PCAdvance,
    input  logic             Flush,
    output logic             IMemReq,
    output logic [dataW-1:0] IMemAddr,
    input  logic             IMemGnt,
    input  logic             IMemRValid,
    input  logic [dataW-1:0] IMemRData,
    output logic             InstrValid,
    input  logic             InstrReady,
    output logic [dataW-1:0] Instr,
    output logic [dataW-1:0] InstrAddr,
    output logic             Misaligned
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] c_depth = CW'(DEPTH);

    fetch_state_t     r_state;
    fetch_state_t     w_next_state;
    logic [dataW-1:0] r_inflight_addr;
    logic             r_misaligned;
    logic             r_run;
    logic [CW-1:0]    w_count;
    logic [CW-1:0]    w_occupancy;
    logic             w_full;
    logic             w_empty;
    logic             w_space;
    logic             w_aligned;
    logic             w_push;
    logic             w_pop;
    fetch_entry_t     w_push_entry;
    fetch_entry_t     w_head;

    // Occupancy counts the outstanding fetch so a returning word always has a slot
    assign w_occupancy = w_count + CW'(r_state == WAIT);
    assign w_space     = !w_full && (w_occupancy < c_depth);
    assign w_aligned   = ((ProgAddr[1:0] & INSTR_ALIGN_MASK) == 2'b00);

    assign w_push = (r_state == WAIT) && IMemRValid && !Flush;
    assign w_pop  = InstrValid && InstrReady && !Flush;

    assign w_push_entry.addr  = r_inflight_addr;
    assign w_push_entry.instr = IMemRData;

    assign IMemAddr   = ProgAddr;
    assign InstrValid = !w_empty;
    assign Instr      = w_head.instr;
    assign InstrAddr  = w_head.addr;
    assign Misaligned = r_misaligned;

    always_comb begin
        w_next_state = r_state;
        IMemReq      = 1'b0;
        PCAdvance    = 1'b0;
        case (r_state)
            IDLE: begin
                // r_run keeps the request low for the first cycle after reset
                IMemReq = r_run && w_space && !Flush && !r_misaligned && w_aligned;
                if (IMemReq && IMemGnt) begin
                    PCAdvance    = 1'b1;
                    w_next_state = WAIT;
                end
            end
            WAIT: begin
                if (IMemRValid) begin
                    w_next_state = IDLE;
                end else if (Flush) begin
                    w_next_state = DRAIN;
                end
            end
            DRAIN: begin
                if (IMemRValid) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state         <= IDLE;
            r_inflight_addr <= '0;
            r_misaligned    <= 1'b0;
            r_run           <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_run   <= 1'b1;
            if (PCAdvance) begin
                r_inflight_addr <= ProgAddr;
            end
            if (Flush) begin
                r_misaligned <= 1'b0;
            end else if ((r_state == IDLE) && r_run && w_space && !w_aligned) begin
                r_misaligned <= 1'b1;
            end
        end
    end

    ifetch_queue #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk     (clock),
        .rst     (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_clear (Flush),
        .i_wdata (w_push_entry),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

endmodule
`default_nettype wire

// File: doc/ifetch_r32i.md
Name: ifetch_r32i

Overview:
Instruction fetch stage directly downstream of the RV32I program counter. Consumes ProgAddr and issues word reads to instruction memory over a req/gnt + rvalid handshake. Buffers returned instructions, tagged with their address, in a small queue that feeds decode over valid/ready. Tells the PC when to step, and discards stale fetches when a taken branch flushes the front end.

Parameters:
dataW, 32, address and instruction width
DEPTH, 2, instruction queue entries; power of 2, at least 2

Ports:
clock  input  1  system clock; all state changes on rising edge
reset  input  1  synchronous, active-high reset
ProgAddr  input  dataW  current PC value from PC stage
PCAdvance  output  1  1-cycle pulse: request for ProgAddr granted; PC may increment
Flush  input  1  taken branch/redirect; discard queued and in-flight fetches
IMemReq  output  1  instruction memory read request
IMemAddr  output  dataW  request address; equals ProgAddr while IMemReq=1
IMemGnt  input  1  memory accepts request; ignored when IMemReq=0
IMemRValid  input  1  read data valid
IMemRData  input  dataW  read data
InstrValid  output  1  queue head valid to decode
InstrReady  input  1  decode accepts head
Instr  output  dataW  head instruction
InstrAddr  output  dataW  address of head instruction
Misaligned  output  1  sticky: ProgAddr[1:0] != 0 at request time

Behaviour:
- Reset (synchronous): state IDLE, queue empty, Misaligned=0. IMemReq, PCAdvance and InstrValid are 0 in the cycle after reset is sampled.
- At most one outstanding memory request. Queue space rule: count + (state==WAIT) < DEPTH.
- FSM states: IDLE, WAIT, DRAIN.
- IDLE:
  - IMemReq = space && !Flush && !Misaligned && ProgAddr[1:0]==0. This is combinational; the address is stable because the PC only steps on PCAdvance.
  - If IMemReq && IMemGnt: PCAdvance=1 in the same cycle, capture ProgAddr into the in-flight address register, go to WAIT.
  - If ProgAddr[1:0] != 0 and there is space: set Misaligned and issue no request.
- WAIT:
  - On IMemRValid && !Flush: push {in-flight addr, IMemRData}, go to IDLE. The next request can be granted in the following cycle.
  - On Flush && IMemRValid in the same cycle: drop the data, go to IDLE.
  - On Flush && !IMemRValid: go to DRAIN.
- DRAIN: IMemReq=0. On IMemRValid, drop the data and go to IDLE.
- IMemRValid in IDLE (stale response, e.g. after reset mid-transaction) is ignored.
- Flush:
  - Empties the queue next cycle; InstrValid=0 in the cycle after Flush.
  - Clears Misaligned.
  - A push and a pop in the same cycle as Flush are both cancelled.
  - ProgAddr is the redirect target from the cycle after Flush.
- Queue:
  - Registered FIFO; read/write pointers wrap modulo DEPTH; count 0..DEPTH.
  - Simultaneous push and pop when full or empty-with-push are legal; count is unchanged on push+pop.
  - Pop only when InstrValid && InstrReady. Instr and InstrAddr hold stable while InstrValid && !InstrReady.
- Latency: grant in cycle N; earliest IMemRValid at N+1; InstrValid at N+2. Peak throughput is 1 instruction per 2 cycles.

Decomposition:
- Shared package ifetch_pkg:
  - fetch_state_t enum {IDLE, WAIT, DRAIN}.
  - fetch_entry_t packed struct {addr[dataW-1:0], instr[dataW-1:0]}.
  - Constant INSTR_ALIGN_MASK = 2'b11.
- One sub-module: ifetch_queue, a parameterised synchronous FIFO with push, pop, clear, full, empty and count.

Test Plan:
- Reset then ProgAddr=0x0, IMemGnt=1, IMemRValid one cycle after each grant, InstrReady=1 -> grants at 0x0, 0x4, 0x8; InstrValid pulses with InstrAddr 0x0/0x4/0x8 and Instr = returned data; PCAdvance once per grant.
- InstrReady=0, memory always responds -> exactly DEPTH=2 entries accepted, then IMemReq=0. Raise InstrReady -> head 0x0 popped and fetch resumes at 0x8.
- Grant at 0x10, Flush asserted one cycle before IMemRValid, ProgAddr=0x40 -> response for 0x10 discarded (DRAIN), next request to 0x40, first InstrAddr after flush = 0x40.
- Flush coincident with IMemRValid while queue holds 0x20 -> queue empty next cycle, no InstrValid for 0x20/0x24, state IDLE.
- ProgAddr=0x42 in IDLE -> no IMemReq, Misaligned=1 and held. Flush with ProgAddr=0x80 -> Misaligned=0, request to 0x80.
- reset asserted in WAIT, then a stray IMemRValid with data 0xDEADBEEF -> nothing pushed, InstrValid stays 0.
